// File: rtl/comefa_controller_pkg.sv
// rtl/comefa_controller_pkg.sv - shared widths, field positions and FSM encoding for the comefa sequencer
package comefa_controller_pkg;

    localparam int AWIDTH   = 9;
    localparam int DWIDTH   = 40;
    localparam int RF_WIDTH = 8;

    localparam int SEL_MSB  = DWIDTH - 1;
    localparam int SEL_LSB  = DWIDTH - 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    // The selector bits are control-only; the compute RAMs see them as zero.
    function automatic logic [DWIDTH-1:0] micro_instr(input logic [DWIDTH-1:0] word);
        return {2'b00, word[SEL_LSB-1:0]};
    endfunction

    function automatic logic [RF_WIDTH-1:0] repeat_count(
        input logic [1:0]          sel,
        input logic [RF_WIDTH-1:0] rf0,
        input logic [RF_WIDTH-1:0] rf1,
        input logic [RF_WIDTH-1:0] rf2,
        input logic [RF_WIDTH-1:0] rf3
    );
        logic [RF_WIDTH-1:0] r;
        case (sel)
            2'd0:    r = rf0;
            2'd1:    r = rf1;
            2'd2:    r = rf2;
            default: r = rf3;
        endcase
        return (r == '0) ? RF_WIDTH'(1) : r;
    endfunction

endpackage

// File: rtl/comefa_controller_if.sv
// rtl/comefa_controller_if.sv - CPU, instruction dpram and comefa RAM signals of the sequencer
interface comefa_controller_if;
    import comefa_controller_pkg::*;

    logic                start;
    logic                done;
    logic [AWIDTH-1:0]   stored_instr_addr;
    logic [AWIDTH-1:0]   stored_instr_start_addr;
    logic [AWIDTH-1:0]   stored_instr_end_addr;
    logic [DWIDTH-1:0]   stored_instruction;
    logic [AWIDTH-1:0]   exec_instr_addr;
    logic [DWIDTH-1:0]   exec_instruction;
    logic                execute;
    logic [RF_WIDTH-1:0] rf0;
    logic [RF_WIDTH-1:0] rf1;
    logic [RF_WIDTH-1:0] rf2;
    logic [RF_WIDTH-1:0] rf3;

    modport master (
        input  start, stored_instr_start_addr, stored_instr_end_addr, stored_instruction,
        input  rf0, rf1, rf2, rf3,
        output done, stored_instr_addr, exec_instr_addr, exec_instruction, execute
    );

    modport slave (
        output start, stored_instr_start_addr, stored_instr_end_addr, stored_instruction,
        output rf0, rf1, rf2, rf3,
        input  done, stored_instr_addr, exec_instr_addr, exec_instruction, execute
    );

endinterface

// File: rtl/comefa_controller.sv
// rtl/comefa_controller.sv - expands the stored macro-instruction window into comefa micro-instruction writes
module comefa_controller
    import comefa_controller_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    comefa_controller_if.master bus
);

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   pc_q, pc_d;
    logic [AWIDTH-1:0]   fetch_addr_q, fetch_addr_d;
    logic [AWIDTH-1:0]   exec_addr_q, exec_addr_d;
    logic [DWIDTH-1:0]   exec_instr_q, exec_instr_d;
    logic [RF_WIDTH-1:0] i_q, i_d;
    logic [RF_WIDTH-1:0] n_q, n_d;
    logic                execute_q, execute_d;
    logic                done_q, done_d;
    logic [1:0]          sel;

    assign sel = bus.stored_instruction[SEL_MSB:SEL_LSB];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            fetch_addr_q <= '0;
            exec_addr_q  <= '0;
            exec_instr_q <= '0;
            i_q          <= '0;
            n_q          <= '0;
            execute_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            exec_addr_q  <= exec_addr_d;
            exec_instr_q <= exec_instr_d;
            i_q          <= i_d;
            n_q          <= n_d;
            execute_q    <= execute_d;
            done_q       <= done_d;
        end
    end

    // Output registers are loaded on the edge entering a state, so execute
    // is high exactly while ISSUE is current; done lands the cycle after DONE.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        exec_addr_d  = exec_addr_q;
        exec_instr_d = exec_instr_q;
        i_d          = i_q;
        n_d          = n_q;
        execute_d    = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    pc_d         = bus.stored_instr_start_addr;
                    fetch_addr_d = bus.stored_instr_start_addr;
                    state_d      = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                n_d          = repeat_count(sel, bus.rf0, bus.rf1, bus.rf2, bus.rf3);
                i_d          = '0;
                exec_addr_d  = bus.stored_instruction[AWIDTH-1:0];
                exec_instr_d = micro_instr(bus.stored_instruction);
                execute_d    = 1'b1;
                state_d      = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (i_q == n_q - 1'b1) begin
                    if (pc_q == bus.stored_instr_end_addr) begin
                        state_d = ST_DONE;
                    end else begin
                        pc_d         = pc_q + 1'b1;
                        fetch_addr_d = pc_q + 1'b1;
                        state_d      = ST_FETCH;
                    end
                end else begin
                    i_d         = i_q + 1'b1;
                    exec_addr_d = exec_addr_q + 1'b1;
                    execute_d   = 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // A start still held from the finished run must not retrigger.
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.done              = done_q;
    assign bus.execute           = execute_q;
    assign bus.stored_instr_addr = fetch_addr_q;
    assign bus.exec_instr_addr   = exec_addr_q;
    assign bus.exec_instruction  = exec_instr_q;

endmodule

// File: tb/tb_comefa_controller.sv
// tb/tb_comefa_controller.sv - randomized scoreboard bench for comefa_controller
module tb_comefa_controller;
    import comefa_controller_pkg::*;

    typedef struct {
        int                cyc;
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] instr;
    } exp_t;

    typedef logic [3:0][RF_WIDTH-1:0] rf_set_t;

    localparam int MEM_DEPTH = 1 << AWIDTH;

    logic clk = 1'b0;
    logic reset = 1'b1;

    comefa_controller_if bus();

    comefa_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DWIDTH-1:0] mem [0:MEM_DEPTH-1];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exec_count = 0;
    exp_t exp_q[$];
    int   done_q[$];
    exp_t mon_e;

    // Instruction dpram, port B: one-cycle registered read
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.stored_instruction <= mem[bus.stored_instr_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.execute) begin
                exec_count++;
                if (exp_q.size() == 0) begin
                    fail("unexpected_execute");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("exec_cycle", 64'(cyc), 64'(mon_e.cyc));
                    check("exec_addr", 64'(bus.exec_instr_addr), 64'(mon_e.addr));
                    check("exec_instr", 64'(bus.exec_instruction), 64'(mon_e.instr));
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) fail("unexpected_done");
                else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
            end
        end
    end

    function automatic logic [DWIDTH-1:0] mk_word(input logic [1:0] sel, input logic [AWIDTH-1:0] base);
        logic [DWIDTH-1:0] w;
        w = DWIDTH'({$urandom, $urandom});
        w[DWIDTH-1 -: 2] = sel;
        w[AWIDTH-1:0]    = base;
        return w;
    endfunction

    task automatic set_rf(input rf_set_t rf);
        bus.rf0 = rf[0];
        bus.rf1 = rf[1];
        bus.rf2 = rf[2];
        bus.rf3 = rf[3];
    endtask

    // Reference: first issue 3 cycles after start, each word costs N issues plus
    // 2 bubbles, done 2 cycles after the final issue. Word 0 uses rfa, later words rfb.
    task automatic model_push(input int sa, input int ea, input rf_set_t rfa, input rf_set_t rfb, input int c);
        int pc, t, n, r, sel;
        logic [DWIDTH-1:0] w;
        exp_t e;
        t  = c + 3;
        pc = sa;
        for (int k = 0; k <= MEM_DEPTH; k++) begin
            w   = mem[pc];
            sel = int'(w[DWIDTH-1 -: 2]);
            r   = (k == 0) ? int'(rfa[sel]) : int'(rfb[sel]);
            n   = (r == 0) ? 1 : r;
            for (int i = 0; i < n; i++) begin
                e.cyc   = t + i;
                e.addr  = AWIDTH'((int'(w[AWIDTH-1:0]) + i) % MEM_DEPTH);
                e.instr = {2'b00, w[DWIDTH-3:0]};
                exp_q.push_back(e);
            end
            t += n + 2;
            if (pc == ea) break;
            pc = (pc + 1) % MEM_DEPTH;
        end
        done_q.push_back(t - 1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (done_q.size() != 0) begin
            fail("done_timeout");
            done_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_execute"}, 64'(bus.execute), 64'd0);
        check({tag, "_stored_addr"}, 64'(bus.stored_instr_addr), 64'd0);
        check({tag, "_exec_addr"}, 64'(bus.exec_instr_addr), 64'd0);
        check({tag, "_exec_instr"}, 64'(bus.exec_instruction), 64'd0);
    endtask

    task automatic launch(input int sa, input int ea, input rf_set_t rfa, input rf_set_t rfb);
        @(negedge clk);
        bus.stored_instr_start_addr = AWIDTH'(sa);
        bus.stored_instr_end_addr   = AWIDTH'(ea);
        set_rf(rfa);
        bus.start = 1'b1;
        model_push(sa, ea, rfa, rfb, cyc);
    endtask

    task automatic do_run(input int sa, input int ea, input rf_set_t rfa, input rf_set_t rfb, input bit drop_early);
        int k0;
        launch(sa, ea, rfa, rfb);
        repeat (3) @(negedge clk);
        set_rf(rfb);
        if (drop_early) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_done();
        k0 = exec_count;
        repeat (6) @(negedge clk);
        check("no_retrigger", 64'(exec_count), 64'(k0));
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("leftover_issues", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rf_set_t rfa, rfb;
        int sa, ea, len, k;

        bus.start = 1'b0;
        bus.stored_instr_start_addr = '0;
        bus.stored_instr_end_addr = '0;
        set_rf('0);
        for (int a = 0; a < MEM_DEPTH; a++) mem[a] = mk_word(2'($urandom), AWIDTH'($urandom));

        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // Single word, single issue
        mem[3] = mk_word(2'd0, AWIDTH'(10));
        rfa = '0;
        rfa[0] = 8'd1;
        do_run(3, 3, rfa, rfa, 1'b0);

        // Five words of four issues each
        for (int w = 0; w < 5; w++) mem[3 + w] = mk_word(2'd1, AWIDTH'(w * 4));
        rfa = '0;
        rfa[1] = 8'd4;
        do_run(3, 7, rfa, rfa, 1'b0);

        // Zero count treated as one, then base wrap past the top row
        mem[20] = mk_word(2'd2, AWIDTH'(100));
        mem[21] = mk_word(2'd3, AWIDTH'(511));
        rfa = '0;
        rfa[3] = 8'd3;
        do_run(20, 21, rfa, rfa, 1'b1);

        // Window with end below start wraps through the top of memory
        for (int w = 0; w < 4; w++) mem[(510 + w) % MEM_DEPTH] = mk_word(2'($urandom), AWIDTH'($urandom));
        rfa = {8'd2, 8'd0, 8'd3, 8'd1};
        rfb = {8'd1, 8'd2, 8'd0, 8'd2};
        do_run(510, 1, rfa, rfb, 1'b0);

        // Asynchronous reset in the middle of issuing
        for (int w = 0; w < 5; w++) mem[3 + w] = mk_word(2'd1, AWIDTH'(w * 4));
        rfa = '0;
        rfa[1] = 8'd4;
        launch(3, 7, rfa, rfa);
        k = 0;
        while (!bus.execute && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!bus.execute) fail("mid_issue_wait");
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        exp_q.delete();
        done_q.delete();
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_run(3, 7, rfa, rfa, 1'b0);

        for (int r = 0; r < 20; r++) begin
            sa  = int'($urandom_range(0, MEM_DEPTH - 1));
            len = int'($urandom_range(1, 4));
            ea  = (sa + len - 1) % MEM_DEPTH;
            for (int w = 0; w < len; w++) mem[(sa + w) % MEM_DEPTH] = mk_word(2'($urandom), AWIDTH'($urandom));
            for (int j = 0; j < 4; j++) begin
                rfa[j] = RF_WIDTH'($urandom_range(0, 4));
                rfb[j] = RF_WIDTH'($urandom_range(0, 4));
            end
            do_run(sa, ea, rfa, rfb, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
